// File: rtl/frame_buffer_byte_streamer_if.sv
// Byte-streamer bus: RAM read port, R/G/B byte handshake, and frame control.
interface frame_buffer_byte_streamer_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              start;
  logic              busy;
  logic [ADDR_W-1:0] read_address;
  logic [23:0]       output_q;
  logic [7:0]        data_in;
  logic              data_in_valid;
  logic              data_accepted;
  logic              data_end;

  modport master (
    input  start, output_q, data_accepted,
    output busy, read_address, data_in, data_in_valid, data_end
  );

  modport slave (
    output start, output_q, data_accepted,
    input  busy, read_address, data_in, data_in_valid, data_end
  );
endinterface

// File: rtl/frame_buffer_byte_streamer.sv
// Reads one captured frame from the RAM read port and streams it as R,G,B bytes.
// Optional FRAME_HEADER_EN prepends a 3-byte header ('F', pixel count hi, lo).
module frame_buffer_byte_streamer #(
  parameter int unsigned FRAME_PIXELS = 19200,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned RD_LATENCY   = 2
) (
  input  logic                         read_clk,
  input  logic                         reset,
  frame_buffer_byte_streamer_if.master bus
);

  localparam int unsigned LAT_W = 2;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [LAT_W-1:0]  LAT_INIT = LAT_W'(RD_LATENCY - 1);
  localparam logic [15:0]       FP16     = 16'(FRAME_PIXELS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_BYTE_R, S_BYTE_G, S_BYTE_B, S_END, S_HEADER
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [LAT_W-1:0]  lat_cnt;
  logic [15:0]       pixel_gb;
  logic [7:0]        byte_q;
  logic              valid_q;
  logic              end_q;
  logic              busy_q;
`ifdef FRAME_HEADER_EN
  logic [1:0]        hdr_idx;
`endif

  // Address is set on entry to FETCH so it is already stable during FETCH and WAIT.
  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pix_cnt  <= '0;
      rd_addr  <= '0;
      lat_cnt  <= '0;
      pixel_gb <= '0;
      byte_q   <= '0;
      valid_q  <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef FRAME_HEADER_EN
      hdr_idx  <= '0;
`endif
    end else begin
      end_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pix_cnt <= '0;
            rd_addr <= '0;
            busy_q  <= 1'b1;
`ifdef FRAME_HEADER_EN
            hdr_idx <= '0;
            byte_q  <= 8'h46;
            valid_q <= 1'b1;
            state   <= S_HEADER;
`else
            state   <= S_FETCH;
`endif
          end
        end
`ifdef FRAME_HEADER_EN
        S_HEADER: begin
          if (bus.data_accepted) begin
            case (hdr_idx)
              2'd0: begin
                byte_q  <= FP16[15:8];
                hdr_idx <= 2'd1;
              end
              2'd1: begin
                byte_q  <= FP16[7:0];
                hdr_idx <= 2'd2;
              end
              default: begin
                valid_q <= 1'b0;
                state   <= S_FETCH;
              end
            endcase
          end
        end
`endif
        S_FETCH: begin
          lat_cnt <= LAT_INIT;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            pixel_gb <= bus.output_q[15:0];
            byte_q   <= bus.output_q[23:16];
            valid_q  <= 1'b1;
            state    <= S_BYTE_R;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_BYTE_R: begin
          if (bus.data_accepted) begin
            byte_q <= pixel_gb[15:8];
            state  <= S_BYTE_G;
          end
        end
        S_BYTE_G: begin
          if (bus.data_accepted) begin
            byte_q <= pixel_gb[7:0];
            state  <= S_BYTE_B;
          end
        end
        S_BYTE_B: begin
          if (bus.data_accepted) begin
            valid_q <= 1'b0;
            // Terminal compare precedes the increment, so the counter never wraps.
            if (pix_cnt == LAST_PIX) begin
              end_q   <= 1'b1;
              rd_addr <= '0;
              state   <= S_END;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              rd_addr <= pix_cnt + 1'b1;
              state   <= S_FETCH;
            end
          end
        end
        S_END: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          rd_addr <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.read_address  = rd_addr;
  assign bus.data_in       = byte_q;
  assign bus.data_in_valid = valid_q;
  assign bus.data_end      = end_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_frame_buffer_byte_streamer.sv
// Scoreboard bench for frame_buffer_byte_streamer with a registered-q RAM model.
module tb_frame_buffer_byte_streamer;

  localparam int unsigned FP = 300;
  localparam int unsigned AW = 15;
  localparam int unsigned RL = 2;
`ifdef FRAME_HEADER_EN
  localparam int unsigned HDR = 3;
`else
  localparam int unsigned HDR = 0;
`endif
  localparam logic [15:0] FP16 = 16'(FP);

  logic read_clk = 1'b0;
  logic reset;
  always #5 read_clk = ~read_clk;

  frame_buffer_byte_streamer_if #(.ADDR_W(AW)) bus ();

  frame_buffer_byte_streamer #(
    .FRAME_PIXELS(FP), .ADDR_W(AW), .RD_LATENCY(RL)
  ) dut (
    .read_clk(read_clk),
    .reset   (reset),
    .bus     (bus.master)
  );

  logic [23:0] mem [0:(1<<AW)-1];
  always @(posedge read_clk) bus.output_q <= mem[bus.read_address];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int end_cnt = 0;
  int last_acc_cyc = 0;
  int end_cyc = 0;
  logic [7:0] exp_q [$];
  logic [7:0] last3 [3];
  logic       hold_pend = 1'b0;
  logic [7:0] hold_val = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [23:0] pat(input int kind, input int i);
    if (kind == 0) return 24'(i);
    if (i == 0) return 24'hA1B2C3;
    return {8'(8'hA0 + i), 8'(8'h50 + i), 8'(i) ^ 8'h0F};
  endfunction

  task automatic load_mem(input int kind);
    for (int i = 0; i < int'(FP); i++) mem[i] = pat(kind, i);
  endtask

  task automatic push_frame(input int kind);
    logic [23:0] px;
    if (HDR != 0) begin
      exp_q.push_back(8'h46);
      exp_q.push_back(FP16[15:8]);
      exp_q.push_back(FP16[7:0]);
    end
    for (int i = 0; i < int'(FP); i++) begin
      px = pat(kind, i);
      exp_q.push_back(px[23:16]);
      exp_q.push_back(px[15:8]);
      exp_q.push_back(px[7:0]);
    end
  endtask

  always @(posedge read_clk) cyc++;

  // Monitor: pops expected bytes on each handshake, checks holds under backpressure.
  always @(negedge read_clk) begin
    if (reset !== 1'b1) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("hold_stable", {23'd0, bus.data_in_valid, bus.data_in}, {23'd0, 1'b1, hold_val});
      if (bus.data_in_valid && bus.data_accepted) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_byte actual=0x%0h required=none", bus.data_in);
        end else begin
          check("byte", 32'(bus.data_in), 32'(exp_q.pop_front()));
        end
        last3[0] = last3[1];
        last3[1] = last3[2];
        last3[2] = bus.data_in;
        acc_cnt++;
        last_acc_cyc = cyc;
        hold_pend = 1'b0;
      end else if (bus.data_in_valid) begin
        hold_pend = 1'b1;
        hold_val  = bus.data_in;
      end else begin
        hold_pend = 1'b0;
      end
      if (bus.data_end) begin
        end_cnt++;
        end_cyc = cyc;
      end
    end
  end

  task automatic start_frame();
    @(posedge read_clk);
    #1;
    acc_cnt = 0;
    bus.start = 1'b1;
    @(posedge read_clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_end();
    int prev;
    int n;
    prev = end_cnt;
    n = 0;
    while (end_cnt == prev && n < int'(FP) * 12 + 100) begin
      @(posedge read_clk);
      n++;
    end
    check("data_end_seen", 32'(end_cnt), 32'(prev + 1));
    check("data_end_timing", 32'(end_cyc), 32'(last_acc_cyc + 1));
    check("accept_total", 32'(acc_cnt), 32'(3 * FP + HDR));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge read_clk);
    check("idle_after_end", {29'd0, bus.busy, bus.data_end, bus.data_in_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic got;
    int prev;

    bus.start = 1'b1;
    bus.data_accepted = 1'b1;
    reset = 1'b0;
    last3[0] = 8'h00;
    last3[1] = 8'h00;
    last3[2] = 8'h00;

    // Reset held with start high: everything quiet.
    repeat (3) @(negedge read_clk);
    check("rst_read_address", 32'(bus.read_address), 32'd0);
    check("rst_data_in", 32'(bus.data_in), 32'd0);
    check("rst_valid", 32'(bus.data_in_valid), 32'd0);
    check("rst_data_end", 32'(bus.data_end), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Frame B: first-valid latency, pixel 0 = A1B2C3, backpressure at pixel 5 G.
    load_mem(1);
    push_frame(1);
    acc_cnt = 0;
    @(posedge read_clk);
    #2;
    reset = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge read_clk);
      #1;
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.data_in_valid) got = 1'b1;
      else check("rd_addr_fetch_wait", 32'(bus.read_address), 32'd0);
    end
    check("first_valid_latency", 32'(n), (HDR != 0) ? 32'd1 : 32'(1 + RL + 1));
    check("first_byte", 32'(bus.data_in), (HDR != 0) ? 32'h46 : 32'hA1);

    n = 0;
    while (acc_cnt != int'(HDR) + 16 && n < 2000) begin
      @(posedge read_clk);
      #1;
      n++;
    end
    check("reach_pixel5_g", 32'(acc_cnt), 32'(HDR + 16));
    bus.data_accepted = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge read_clk);
      check("backpressure_hold", {23'd0, bus.data_in_valid, bus.data_in}, {23'd0, 1'b1, 8'h55});
      @(posedge read_clk);
      if (k == 6) begin
        #1;
        bus.data_accepted = 1'b1;
      end
    end
    wait_end();

    // Frame A: RAM[i]=i; pixel 299 = 0x00012B ends the stream.
    load_mem(0);
    push_frame(0);
    start_frame();
    wait_end();
    check("last_three_bytes", {8'd0, last3[0], last3[1], last3[2]}, 32'h0000_012B);

    // Reset during pixel 100 BYTE_G: outputs clear before the next edge, no data_end.
    push_frame(0);
    start_frame();
    n = 0;
    while (acc_cnt != int'(HDR) + 301 && n < 4000) begin
      @(posedge read_clk);
      #1;
      n++;
    end
    check("reach_pixel100_g", 32'(acc_cnt), 32'(HDR + 301));
    #1;
    reset = 1'b0;
    #1;
    check("midrst_outputs", {8'd0, bus.data_in_valid, bus.data_end, bus.busy, bus.data_in, 5'd0, bus.read_address[AW-1:5]},
          32'd0);
    check("midrst_addr_lo", 32'(bus.read_address[4:0]), 32'd0);
    exp_q.delete();
    prev = end_cnt;
    repeat (3) @(posedge read_clk);
    check("no_end_after_reset", 32'(end_cnt), 32'(prev));
    #2;
    reset = 1'b1;

    // Restart must stream from address 0 again.
    load_mem(1);
    push_frame(1);
    start_frame();
    wait_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
